sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

Message-schedule stage of the SHA-256 core. It accepts one padded 512-bit message block and produces the 64 schedule words W0..W63, one per round, in lock-step with the controller's `round_en`. It sits directly upstream of the round logic, which forms T1 from W_t and feeds the working-register datapath. It uses a 16-word sliding window, so no 64-word storage is needed.

## Interface
Parameters: none. Widths are fixed by SHA-256.

- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `block_valid`  in  1  Upstream offers a block on `block_in`.
- `block_in`  in  512  Padded message block. Word 0 is `block_in[511:480]`; word 15 is `block_in[31:0]`.
- `block_ready`  out  1  High in IDLE. A block is accepted on any edge where `block_valid & block_ready`.
- `round_en`  in  1  Controller round strobe. Advances the schedule by one word.
- `w_valid`  out  1  High while `W_t` and `round_idx` are meaningful (RUN state).
- `W_t`  out  32  Current schedule word W[round_idx]. Forced to 0 when `w_valid=0`.
- `round_idx`  out  6  Index t of the word currently on `W_t`, 0..63.
- `sched_last`  out  1  `w_valid & (round_idx==63)`.

## Operation
- State: 16×32 window `w[0..15]`, with `w[i]` = W[t+i]; a 6-bit counter; and a 1-bit FSM with states IDLE and RUN.
- `W_t` = `w[0]` when in RUN.
- IDLE:
  - `block_ready=1`; `round_en` is ignored.
  - On accept: `w[i]` ← word i of `block_in`; counter ← 0; go to RUN.
- RUN:
  - `block_ready=0`; `block_valid` is ignored.
  - On an edge with `round_en=1`: `w[i]` ← `w[i+1]` for i = 0..14, and `w[15]` ← σ1(w[14]) + w[9] + σ0(w[1]) + w[0], mod 2^32.
  - On the same edge, the counter increments.
  - If counter==63 at that edge, go to IDLE. The counter wraps to 0 and the window contents become don't-care.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Rotates are 32-bit circular. Shifts fill with zeros. The 4-operand sum truncates to 32 bits, with no carry out.
- The block computes the expansion even for t ≥ 48, where the generated words are never consumed. This is harmless and keeps the logic uniform.
- The block does not generate K constants; the round-logic stage owns them.

## Timing
- Reset values (asserted asynchronously, held while `rst=1`):
  - state=IDLE, counter=0, window=0.
  - Outputs: `block_ready=1`, `w_valid=0`, `W_t=0`, `round_idx=0`, `sched_last=0`.
- Load latency: a block accepted at edge N gives `w_valid=1`, `round_idx=0`, `W_t`=W0 during cycle N+1.
- Each `round_en` edge updates `W_t`/`round_idx` in the following cycle; there is no extra pipeline delay.
- `round_en` may be held high continuously. Then 64 consecutive cycles produce W0..W63, with no bubbles required.
- `round_en` gaps are allowed. The outputs hold stable while `round_en=0`.
- After the `round_en` edge taken at `round_idx=63`, the next cycle shows:
  - `w_valid=0`, `W_t=0`, `round_idx=0`, `block_ready=1`.
  - A new block may be accepted at that cycle's edge. Block-to-block spacing is therefore a minimum of 65 cycles (1 load + 64 rounds).
- Simultaneous events:
  - `round_en` together with an accept in IDLE: the load wins, and `round_en` is ignored.
  - `block_valid` during RUN: ignored. Upstream must hold it until `block_ready`.
- Reset mid-RUN: the block immediately returns to the reset values. The partial block is discarded and no output pulses.
- All outputs are functions of registered state only. There is no combinational path from input to output.

## Test plan
- **Reset values.** Assert `rst` mid-cycle with no clock edge → all outputs take their reset values immediately.
- **"abc" block.** Stimulus: block with W0=0x61626380, W1..W14=0, W15=0x00000018, with `round_en` held high.
  - Cycle after accept: `W_t`=0x61626380, `round_idx=0`.
  - `round_idx=16` → `W_t`=0x61626380.
  - `round_idx=17` → `W_t`=0x000F0000.
  - All 64 words match the software model; `sched_last` is high for exactly one cycle.
- **Gapped `round_en`.** Random `round_en` duty over the "abc" block → the same 64-word sequence. Outputs hold stable on cycles with `round_en=0`.
- **Handshake.**
  - `block_valid` held high across the whole run → exactly one accept per 65 cycles; `block_ready` is low for all RUN cycles.
  - Second block (all words 0xFFFFFFFF) → matches the model.
- **Mid-RUN reset.** Assert `rst` at `round_idx=30` → `w_valid=0` and `W_t=0` immediately. A new block loaded afterwards starts at `round_idx=0` with a correct W0.
- **Load vs `round_en`.** `round_en=1` in IDLE, both with and without `block_valid` → no state change without `block_valid`. With `block_valid`, a clean load occurs and `round_idx=0` the next cycle.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W0..W63 using a
// 16-word sliding window that advances one word per round strobe.
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         block_valid,
    input  logic [511:0] block_in,
    output logic         block_ready,
    input  logic         round_en,
    output logic         w_valid,
    output logic [31:0]  W_t,
    output logic [5:0]   round_idx,
    output logic         sched_last
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_win [16];

    logic        w_load;
    logic        w_advance;
    logic [31:0] w_new;

    function automatic logic [31:0] f_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    assign w_load    = (r_state == ST_IDLE) && block_valid;
    assign w_advance = (r_state == ST_RUN) && round_en;
    assign w_new     = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (block_valid) w_state_next = ST_RUN;
            ST_RUN:  if (round_en && (r_cnt == 6'd63)) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_next;
            if (w_load)
                r_cnt <= 6'd0;
            else if (w_advance)
                r_cnt <= r_cnt + 6'd1;  // wraps to 0 as the last round is taken
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_win
            logic [31:0] w_shift_in;
            if (gi == 15) begin : g_tail
                assign w_shift_in = w_new;
            end else begin : g_body
                assign w_shift_in = r_win[gi+1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_win[gi] <= 32'd0;
                else if (w_load)
                    r_win[gi] <= block_in[511-32*gi -: 32];
                else if (w_advance)
                    r_win[gi] <= w_shift_in;
            end
        end
    endgenerate

    assign block_ready = (r_state == ST_IDLE);
    assign w_valid     = (r_state == ST_RUN);
    assign W_t         = w_valid ? r_win[0] : 32'd0;
    assign round_idx   = r_cnt;
    assign sched_last  = w_valid && (r_cnt == 6'd63);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for the SHA-256 message schedule: reset, "abc" block,
// gapped strobes, back-to-back handshake, mid-run reset and load priority.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         block_valid = 1'b0;
    logic [511:0] block_in = '0;
    logic         block_ready;
    logic         round_en = 1'b0;
    logic         w_valid;
    logic [31:0]  W_t;
    logic [5:0]   round_idx;
    logic         sched_last;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0]  exp_w [64];
    logic [511:0] blk_abc;
    logic [511:0] blk_ones;

    sha256_msg_schedule dut (
        .clk         (clk),
        .rst         (rst),
        .block_valid (block_valid),
        .block_in    (block_in),
        .block_ready (block_ready),
        .round_en    (round_en),
        .w_valid     (w_valid),
        .W_t         (W_t),
        .round_idx   (round_idx),
        .sched_last  (sched_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference expansion over a full 64-entry array
    task automatic build(input logic [511:0] b);
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
            s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
            exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, {31'd0, block_ready}, 32'd1);
        chk({tag, "_valid"}, {31'd0, w_valid}, 32'd0);
        chk({tag, "_wt"}, W_t, 32'd0);
        chk({tag, "_idx"}, {26'd0, round_idx}, 32'd0);
        chk({tag, "_last"}, {31'd0, sched_last}, 32'd0);
    endtask

    // Present a block and wait (bounded) for the accepting edge
    task automatic send_block(input logic [511:0] b);
        int k;
        k = 0;
        block_valid = 1'b1;
        block_in    = b;
        while (!block_ready && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) chk("send_timeout", 32'd0, 32'd1);
        step();
        block_valid = 1'b0;
    endtask

    initial begin
        int t, cyc, accepts, last_cnt;
        logic busy;

        blk_abc  = {32'h61626380, 448'd0, 32'h00000018};
        blk_ones = {512{1'b1}};

        // Asynchronous reset, asserted between clock edges
        #2 rst = 1'b1;
        #1 chk_idle("reset");
        step();
        step();
        rst = 1'b0;
        $display("reset: outputs checked");

        // round_en alone in IDLE must not change state
        round_en = 1'b1;
        step(); step(); step();
        chk_idle("idle_round_en");

        // "abc" with round_en held high, also during the load edge
        build(blk_abc);
        send_block(blk_abc);
        last_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            chk("abc_valid", {31'd0, w_valid}, 32'd1);
            chk("abc_ready", {31'd0, block_ready}, 32'd0);
            chk("abc_idx", {26'd0, round_idx}, i);
            chk("abc_w", W_t, exp_w[i]);
            if (i == 0)  chk("abc_w0", W_t, 32'h61626380);
            if (i == 16) chk("abc_w16", W_t, 32'h61626380);
            if (i == 17) chk("abc_w17", W_t, 32'h000F0000);
            if (sched_last) last_cnt++;
            step();
        end
        if (sched_last) last_cnt++;
        chk("abc_last_count", last_cnt, 32'd1);
        chk_idle("abc_end");
        round_en = 1'b0;
        $display("block abc continuous: 64 words compared");

        // Same block with random round_en gaps
        send_block(blk_abc);
        t = 0;
        cyc = 0;
        while (t < 64 && cyc < 1000) begin
            chk("gap_idx", {26'd0, round_idx}, t);
            chk("gap_w", W_t, exp_w[t]);
            chk("gap_last", {31'd0, sched_last}, {31'd0, t == 63});
            round_en = $urandom_range(0, 1) != 0;
            step();
            if (round_en) t++;
            cyc++;
        end
        round_en = 1'b0;
        if (t < 64) chk("gap_timeout", t, 32'd64);
        chk_idle("gap_end");
        $display("block abc gapped: %0d cycles", cyc);

        // block_valid held across two runs of all-ones blocks
        build(blk_ones);
        block_valid = 1'b1;
        block_in    = blk_ones;
        round_en    = 1'b1;
        busy = 1'b0;
        t = 0;
        accepts = 0;
        for (int c = 0; c < 130; c++) begin
            chk("hs_ready", {31'd0, block_ready}, {31'd0, !busy});
            chk("hs_valid", {31'd0, w_valid}, {31'd0, busy});
            if (busy) chk("hs_w", W_t, exp_w[t]);
            step();
            if (!busy) begin
                busy = 1'b1;
                t = 0;
                accepts++;
            end else if (t == 63) begin
                busy = 1'b0;
            end else begin
                t++;
            end
        end
        block_valid = 1'b0;
        round_en    = 1'b0;
        chk("hs_accepts", accepts, 32'd2);
        chk_idle("hs_end");
        $display("handshake: %0d accepts in 130 cycles", accepts);

        // Reset in the middle of a run
        build(blk_abc);
        send_block(blk_abc);
        round_en = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("mid_idx30", {26'd0, round_idx}, 32'd30);
        chk("mid_w30", W_t, exp_w[30]);
        round_en = 1'b0;
        #2 rst = 1'b1;
        #1 chk_idle("mid_reset");
        step();
        rst = 1'b0;
        build(blk_ones);
        send_block(blk_ones);
        chk("post_idx", {26'd0, round_idx}, 32'd0);
        chk("post_w0", W_t, 32'hFFFFFFFF);
        round_en = 1'b1;
        step();
        round_en = 1'b0;
        chk("post_idx1", {26'd0, round_idx}, 32'd1);
        chk("post_w1", W_t, exp_w[1]);
        step();
        chk("post_hold", W_t, exp_w[1]);
        $display("mid-run reset: reload checked");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
